dmem_responder: RTL

//   Memory-side responder for the core's data-memory port (addr/rmask/wmask/wdata -> rdata/resp).

---
 rtl/dmem_responder_pkg.sv | 38 +++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder_word_array.sv | 42 ++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types, constants and lane helper for the data-memory responder
// Purpose: FSM state encoding, bus widths and the byte-lane masking helper.
// Ports: none (package).
package dmem_responder_pkg;

    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_MASK_W = DMEM_DATA_W / 8;

    // The latency counter covers the full 1..15 LATENCY range.
    localparam int unsigned LAT_CNT_W = $clog2(16);

    // FSM encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        RSP_IDLE = ST_IDLE,
        RSP_BUSY = ST_BUSY,
        RSP_RESP = ST_RESP
    } dmem_rsp_state_t;

    // Zero every byte lane whose mask bit is clear.
    function automatic logic [DMEM_DATA_W-1:0] lane_mask(
        input logic [DMEM_DATA_W-1:0] data,
        input logic [DMEM_MASK_W-1:0] mask
    );
        logic [DMEM_DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < int'(DMEM_MASK_W); i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-memory request/response bus between the LSQ and the responder
// Purpose: bundles the dmem port signals.
// Signals: addr/rmask/wmask/wdata (initiator -> responder),
//          ready/rdata/resp/err (responder -> initiator).
// Modports: master = request initiator, slave = memory responder.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic [DMEM_DATA_W-1:0] addr;
    logic [DMEM_MASK_W-1:0] rmask;
    logic [DMEM_MASK_W-1:0] wmask;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   ready;
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   resp;
    logic                   err;

    modport master (
        output addr, rmask, wmask, wdata,
        input  ready, rdata, resp, err
    );

    modport slave (
        input  addr, rmask, wmask, wdata,
        output ready, rdata, resp, err
    );

endinterface

// File: rtl/dmem_responder_word_array.sv
// rtl/dmem_responder_word_array.sv - byte-enabled 32-bit word storage for the data-memory responder
// Purpose: 2**ADDR_WIDTH x 32 array, combinational read port, clocked write port
//          with per-byte enables. Contents are not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   wbe    in  byte enables for the write
//   waddr  in  write word index
//   wdata  in  write data, lane-aligned
//   raddr  in  read word index
//   rdata  out read data (combinational)
module dmem_word_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DMEM_MASK_W-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [DMEM_DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(DMEM_MASK_W); i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side responder for the core data-memory port
// Purpose: accepts one word-aligned request at a time, answers LATENCY cycles
//          later with a one-cycle resp pulse, serving reads and byte-enabled
//          writes from an on-chip scratchpad at BASE_ADDR.
// Ports:
//   clk    in  clock, all state on rising edge
//   rst_n  in  asynchronous active-low reset
//   dmem   slave side of dmem_responder_if
//          (addr/rmask/wmask/wdata in, ready/rdata/resp/err out)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h1ECE_B000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  dmem
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    logic [1:0]              state_q, state_d;
    logic [LAT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:2]             addr_q, addr_d;
    logic [DMEM_MASK_W-1:0]  rmask_q, rmask_d;
    logic [DMEM_MASK_W-1:0]  wmask_q, wmask_d;
    logic [DMEM_DATA_W-1:0]  wdata_q, wdata_d;

    logic                    ready;
    logic                    accept;
    logic                    resp;
    logic                    in_range;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [DMEM_DATA_W-1:0]  mem_rdata;
    logic                    unused_addr_lsbs;

    // Byte offset within the word carries no information for a word port.
    assign unused_addr_lsbs = ^dmem.addr[1:0];

    assign ready  = (state_q != ST_BUSY);
    assign accept = ready && ((|dmem.rmask) || (|dmem.wmask));
    assign resp   = (state_q == ST_RESP);

    // BASE_ADDR is aligned to the storage size, so the range check reduces
    // to matching the address bits above the word index.
    assign in_range = (addr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign word_idx = addr_q[ADDR_WIDTH+1:2];

    // The write lands at the edge that closes the RESP cycle, so a combined
    // read+write returns the pre-write word.
    assign mem_we = resp && in_range && (|wmask_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rmask_d = rmask_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new request is taken in IDLE or RESP. With LATENCY=1 the counter
        // loads 0, giving one BUSY cycle so resp still follows the accept
        // edge by exactly LATENCY cycles.
        if (accept) begin
            state_d = ST_BUSY;
            cnt_d   = LAT_LOAD;
            addr_d  = dmem.addr[31:2];
            rmask_d = dmem.rmask;
            wmask_d = dmem.wmask;
            wdata_d = dmem.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rmask_q <= rmask_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
        end
    end

    dmem_word_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_word_array (
        .clk   (clk),
        .we    (mem_we),
        .wbe   (wmask_q),
        .waddr (word_idx),
        .wdata (wdata_q),
        .raddr (word_idx),
        .rdata (mem_rdata)
    );

    assign dmem.ready = ready;
    assign dmem.resp  = resp;
    assign dmem.err   = resp && !in_range;
    assign dmem.rdata = (resp && in_range) ? lane_mask(mem_rdata, rmask_q) : '0;

endmodule
